// File: rtl/shift_rows_stage_if.sv
// Valid/ready bundle for the ShiftRows pipeline stage.
// Ports: in_* (state, mode, tag, handshake), out_* (result, tag, handshake).
interface shift_rows_stage_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic              in_inverse;
    logic [32*NB-1:0]  in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid,
        output in_inverse,
        output in_data,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  in_inverse,
        input  in_data,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tag
    );
endinterface

// File: rtl/shift_rows_stage.sv
// Rijndael (Inv)ShiftRows stage: combinational shift, 2-entry output buffer.
// Ports: clock, reset_n (async low), bus (slave handshake), occupancy (0..2).
module shift_rows_stage #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    shift_rows_stage_if.slave    bus,
    output logic [1:0]           occupancy
);
    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_stage: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_stage: TAG_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     data;
    } entry_t;

    // 256-bit states skip an extra position on rows 2 and 3.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2) begin
            return r + 1;
        end
        return r;
    endfunction

    // Byte (r,c) sits at bits [8*(4*NB-1-(4c+r)) +: 8]; byte 0 is the MSB.
    function automatic logic [W-1:0] shift_state(
        input logic [W-1:0] d,
        input logic         inv
    );
        logic [W-1:0] q;
        int           src;
        q   = '0;
        src = 0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) begin
                    src = (c - row_off(r) + NB) % NB;
                end else begin
                    src = (c + row_off(r)) % NB;
                end
                q[8*(4*NB-1-(4*c+r)) +: 8] =
                    d[8*(4*NB-1-(4*src+r)) +: 8];
            end
        end
        return q;
    endfunction

    state_e state_q;
    state_e state_d;
    logic   rdy_q;
    logic   rdy_d;
    entry_t out_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   drain;
    logic   load_out;
    logic   load_skid;
    logic   skid_to_out;

    assign accept = bus.in_valid && rdy_q;
    assign drain  = bus.out_valid && bus.out_ready;

    assign in_entry.tag  = bus.in_tag;
    assign in_entry.data = shift_state(bus.in_data, bus.in_inverse);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d = FULL;
                end else if (!accept && drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // A new state lands in the output register whenever that register is
    // free or being drained; it only goes to the skid register when the
    // output register is holding under backpressure.
    always_comb begin
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        unique case (state_q)
            EMPTY: begin
                load_out = accept;
            end
            ONE: begin
                load_out  = accept && drain;
                load_skid = accept && !drain;
            end
            FULL: begin
                skid_to_out = drain;
            end
            default: begin
                load_out = 1'b0;
            end
        endcase
        rdy_d = (state_d != FULL);
    end

    // Registered ready keeps in_ready off the out_ready path and holds it
    // low through reset until the first clock edge afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
        end else if (skid_to_out) begin
            out_q <= skid_q;
        end else if (load_out) begin
            out_q <= in_entry;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= in_entry;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = out_q.data;
    assign bus.out_tag   = out_q.tag;
    assign occupancy     = state_q;

endmodule

// File: doc/shift_rows_stage.md
SHIFT_ROWS_STAGE -- requirements
Module: shift_rows_stage

Interface
REQ-001 SHALL have parameter NB, default 4, meaning the number of state columns; legal values are 4, 6 and 8, giving 128-, 192- and 256-bit Rijndael states.
REQ-002 SHALL have parameter TAG_W, default 4, meaning the width of a sideband tag carried alongside each state.
REQ-003 SHALL have the port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the port in_valid, input, 1 bit: the input state is valid.
REQ-006 SHALL have the port in_ready, output, 1 bit: the block can accept an input state.
REQ-007 SHALL have the port in_inverse, input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows; it is sampled with in_data.
REQ-008 SHALL have the port in_data, input, 32*NB bits: the input state.
REQ-009 SHALL have the port in_tag, input, TAG_W bits: the sideband tag, passed through unmodified.
REQ-010 SHALL have the port out_valid, output, 1 bit: the output state is valid.
REQ-011 SHALL have the port out_ready, input, 1 bit: the downstream stage accepts the output state.
REQ-012 SHALL have the port out_data, output, 32*NB bits: the shifted state.
REQ-013 SHALL have the port out_tag, output, TAG_W bits: the tag that entered with the state on out_data.
REQ-014 SHALL have the port occupancy, output, 2 bits: the number of states held internally (0..2).

Function
REQ-015 SHALL map state bytes so that byte (r,c) occupies data bits [8*(4*NB-1-(4c+r)) +: 8], i.e. byte 0 is the MSB and the state is column-major, as in FIPS-197.
REQ-016 SHALL use row offsets s[0..3] = {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-017 SHALL compute the forward output as out(r,c) = in(r,(c+s[r]) mod NB).
REQ-018 SHALL compute the inverse output as out(r,c) = in(r,(c-s[r]+NB) mod NB).
REQ-019 SHALL make a parameter value outside {4,6,8} a elaboration-time error.
REQ-020 SHALL compute the transform combinationally on the input side and register the result; latency from accept to out_valid is exactly 1 cycle when the output is empty.
REQ-021 SHALL accept an input ("transfer") in a cycle where in_valid && in_ready.
REQ-022 SHALL complete an output in a cycle where out_valid && out_ready.
REQ-023 SHALL be a 2-entry buffer: an output register plus a skid register.
REQ-024 SHALL drive in_ready = (occupancy < 2); in_ready is a registered signal and SHALL NOT depend combinationally on out_ready.
REQ-025 SHALL use these states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
REQ-026 SHALL, in EMPTY with an accept, go to ONE.
REQ-027 SHALL, in ONE with an accept and no drain, go to FULL, with the new state written to the skid register.
REQ-028 SHALL, in ONE with an accept and a drain, stay in ONE, with the new state written to the output register.
REQ-029 SHALL, in ONE with a drain and no accept, go to EMPTY.
REQ-030 SHALL, in FULL with a drain, move the skid register to the output register and go to ONE; no accept is possible in FULL.
REQ-031 SHALL preserve order; tag and data SHALL never be separated or reordered.
REQ-032 SHALL hold out_data and out_tag stable while out_valid && !out_ready.
REQ-033 SHALL sample in_inverse per transaction, so mixed forward/inverse traffic back-to-back yields a per-state correct result.
REQ-034 SHALL sustain throughput of one state per cycle when out_ready is held at 1.
REQ-035 SHALL ignore in_data, in_tag and in_inverse when in_valid=0.

Reset
REQ-036 SHALL, on reset_n=0, immediately and asynchronously clear out_valid=0, occupancy=0, in_ready=0 (while asserted), out_data=0 and out_tag=0.
REQ-037 SHALL discard any state in flight when reset is asserted mid-operation; no partial output appears after release.
REQ-038 SHALL raise in_ready=1 on the first rising clock edge after reset_n deasserts.

Verification
REQ-039 SHALL verify FIPS-197 forward: NB=4, in_inverse=0, in_data=d42711aee0bf98f1b8b45de51e415230 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
REQ-040 SHALL verify FIPS-197 inverse: NB=4, in_inverse=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> d42711aee0bf98f1b8b45de51e415230; a forward/inverse round trip over 1000 random states returns the original state.
REQ-041 SHALL verify NB=8 offsets: in byte k = k (00..1f), forward -> out_data[255:224]=00050e13.
REQ-042 SHALL verify backpressure: out_ready=0 with 3 states offered -> 2 accepted, occupancy=2, in_ready=0, out_data stable; release out_ready -> tags emerge in order.
REQ-043 SHALL verify streaming: out_ready=1 with 16 consecutive valid states alternating in_inverse -> 16 outputs on consecutive cycles, each correct for its own mode.
REQ-044 SHALL verify reset mid-stream: reset_n pulsed low with occupancy=2 -> out_valid=0 immediately; no stale output after release.
